// File: rtl/reduce_inject_queue_pkg.sv
// Flit field layout, route/state encodings and routing helper shared by the
// reduction inject queue.
package reduce_inject_queue_pkg;

    // Field offsets above the payload; a flit is PayloadWidth + HDR_WIDTH bits.
    localparam int unsigned HDR_WIDTH   = 50;
    localparam int unsigned DST_X_OFS   = 40;
    localparam int unsigned DST_Y_OFS   = 43;
    localparam int unsigned DST_Z_OFS   = 46;
    localparam int unsigned VALID_OFS   = 49;
    localparam int unsigned COORD_WIDTH = 3;

    typedef enum logic [1:0] {XPOS, YPOS, DROP} route_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    function automatic int unsigned flit_width(input int unsigned payload_width);
        return payload_width + HDR_WIDTH;
    endfunction

    // Dimension order: X first, then Y; anything already aligned in X and Y
    // (Z mismatch or local destination) cannot be injected from here.
    function automatic route_t route_of(input logic [COORD_WIDTH-1:0] dst_x,
                                        input logic [COORD_WIDTH-1:0] dst_y,
                                        input logic [COORD_WIDTH-1:0] cur_x,
                                        input logic [COORD_WIDTH-1:0] cur_y);
        if (dst_x != cur_x)
            return XPOS;
        else if (dst_y != cur_y)
            return YPOS;
        return DROP;
    endfunction

endpackage

// File: rtl/reduce_inject_queue_if.sv
// Upstream flit handshake plus router inject ports of the reduction inject queue.
interface reduce_inject_queue_if #(
    parameter int unsigned FlitWidth  = 82,
    parameter int unsigned ChildWidth = 3
);
    logic [FlitWidth-1:0]            in_flit;
    logic [ChildWidth-1:0]           in_children;
    logic                            in_valid;
    logic                            in_ready;
    logic                            xpos_stall;
    logic                            ypos_stall;
    logic [FlitWidth+ChildWidth-1:0] inject_xpos;
    logic [FlitWidth+ChildWidth-1:0] inject_ypos;

    modport master (
        output in_flit, in_children, in_valid, xpos_stall, ypos_stall,
        input  in_ready, inject_xpos, inject_ypos
    );

    modport slave (
        input  in_flit, in_children, in_valid, xpos_stall, ypos_stall,
        output in_ready, inject_xpos, inject_ypos
    );
endinterface

// File: rtl/reduce_inject_queue_fifo.sv
// Show-ahead FIFO with asynchronous active-low reset; rd_data is the head entry.
module reduce_inject_fifo #(
    parameter int unsigned Width = 85,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [Width-1:0] wr_data,
    input  logic             rd_en,
    output logic [Width-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == CW'(Depth));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= bump(wr_ptr);
            if (do_rd)
                rd_ptr <= bump(rd_ptr);
            if (do_wr && !do_rd)
                count <= count + 1'b1;
            else if (!do_wr && do_rd)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/reduce_inject_queue.sv
// Buffers reduction results with their children field and paces them into the
// router xpos/ypos inject ports in dimension order.
module reduce_inject_queue
    import reduce_inject_queue_pkg::*;
#(
    parameter int unsigned cur_x        = 0,
    parameter int unsigned cur_y        = 0,
    parameter int unsigned cur_z        = 0,
    parameter int unsigned lg_numprocs  = 3,
    parameter int unsigned PayloadWidth = 32,
    parameter int unsigned QueueDepth   = 4,
    parameter int unsigned MinGap       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    reduce_inject_queue_if.slave   bus,
    output logic [15:0]            inj_count,
    output logic [7:0]             drop_count,
    output logic                   route_err
);
    localparam int unsigned FlitWidth      = flit_width(PayloadWidth);
    localparam int unsigned FlitChildWidth = FlitWidth + lg_numprocs;
    localparam int unsigned ValidBitPos    = PayloadWidth + VALID_OFS;
    localparam int unsigned GW             = $clog2(MinGap + 1);
    localparam bit          HAS_GAP        = (MinGap > 1);
    localparam logic [COORD_WIDTH-1:0] CX  = COORD_WIDTH'(cur_x);
    localparam logic [COORD_WIDTH-1:0] CY  = COORD_WIDTH'(cur_y);

    if (cur_x > 7 || cur_y > 7 || cur_z > 7 || QueueDepth < 2 || MinGap < 1) begin : g_bad_params
        $error("reduce_inject_queue: illegal parameter set");
    end

    logic                      full;
    logic                      empty;
    logic                      in_ready;
    logic                      wr_en;
    logic [FlitChildWidth-1:0] head;
    route_t                    route;
    state_t                    state;
    state_t                    next_state;
    logic                      pop;
    logic                      issue_x;
    logic                      issue_y;
    logic                      issue;
    logic                      drop;
    logic [GW-1:0]             gap_cnt;
    logic [FlitChildWidth-1:0] inject_x;
    logic [FlitChildWidth-1:0] inject_y;

    // Invalid flits are accepted but never stored, so they touch no counter.
    assign in_ready     = rst && !full;
    assign wr_en        = bus.in_valid && in_ready && bus.in_flit[ValidBitPos];
    assign bus.in_ready = in_ready;

    reduce_inject_fifo #(
        .Width (FlitChildWidth),
        .Depth (QueueDepth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data ({bus.in_children, bus.in_flit}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign route = route_of(head[PayloadWidth + DST_X_OFS +: COORD_WIDTH],
                            head[PayloadWidth + DST_Y_OFS +: COORD_WIDTH], CX, CY);
    assign issue = issue_x || issue_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // IDLE acts on a non-empty FIFO in the same cycle so an empty-queue
    // enqueue reaches the inject port after only the FIFO write and output register.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE, S_ISSUE: begin
                if (issue && HAS_GAP)
                    next_state = S_GAP;
                else
                    next_state = empty ? S_IDLE : S_ISSUE;
            end
            S_GAP: begin
                if (gap_cnt <= GW'(1))
                    next_state = empty ? S_IDLE : S_ISSUE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        pop     = 1'b0;
        issue_x = 1'b0;
        issue_y = 1'b0;
        drop    = 1'b0;
        if (state != S_GAP && !empty) begin
            unique case (route)
                XPOS: begin
                    issue_x = !bus.xpos_stall;
                    pop     = !bus.xpos_stall;
                end
                YPOS: begin
                    issue_y = !bus.ypos_stall;
                    pop     = !bus.ypos_stall;
                end
                default: begin
                    drop = 1'b1;
                    pop  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt <= '0;
        end else if (issue) begin
            gap_cnt <= GW'(MinGap - 1);
        end else if (state == S_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inject_x   <= '0;
            inject_y   <= '0;
            inj_count  <= '0;
            drop_count <= '0;
            route_err  <= 1'b0;
        end else begin
            inject_x <= issue_x ? head : '0;
            inject_y <= issue_y ? head : '0;
            if (issue)
                inj_count <= inj_count + 1'b1;
            if (drop && drop_count != '1)
                drop_count <= drop_count + 1'b1;
            if (drop)
                route_err <= 1'b1;
        end
    end

    assign bus.inject_xpos = inject_x;
    assign bus.inject_ypos = inject_y;

endmodule

// File: tb/tb_reduce_inject_queue.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_reduce_inject_queue;
    localparam int PW     = 32;
    localparam int LG     = 3;
    localparam int DEPTH  = 4;
    localparam int MINGAP = 2;
    localparam int FW     = PW + 50;
    localparam int FCW    = FW + LG;
    localparam logic [2:0] CUR_X = 3'd0;
    localparam logic [2:0] CUR_Y = 3'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] inj_count;
    logic [7:0]  drop_count;
    logic        route_err;

    reduce_inject_queue_if #(.FlitWidth(FW), .ChildWidth(LG)) bus ();

    reduce_inject_queue #(
        .cur_x        (0),
        .cur_y        (0),
        .cur_z        (0),
        .lg_numprocs  (LG),
        .PayloadWidth (PW),
        .QueueDepth   (DEPTH),
        .MinGap       (MINGAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .inj_count  (inj_count),
        .drop_count (drop_count),
        .route_err  (route_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FCW-1:0] mk(input logic [2:0] ch, input logic [2:0] dx,
                                          input logic [2:0] dy, input logic [2:0] dz,
                                          input logic vb, input logic [31:0] pl,
                                          input logic [39:0] mid);
        logic [FCW-1:0] f;
        f         = '0;
        f[31:0]   = pl;
        f[71:32]  = mid;
        f[74:72]  = dx;
        f[77:75]  = dy;
        f[80:78]  = dz;
        f[81]     = vb;
        f[84:82]  = ch;
        return f;
    endfunction

    // Reference model: a queue of stored entries; an action on the head is
    // allowed once MINGAP edges have passed since the last injection.
    logic [FCW-1:0] mq[$];
    int             cyc_n    = 0;
    int             last_inj = -100;
    int             m_inj    = 0;
    int             m_drop   = 0;
    logic           m_err    = 1'b0;
    logic [FCW-1:0] ex       = '0;
    logic [FCW-1:0] ey       = '0;
    logic [FCW-1:0] h;
    bit             m_ready;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            last_inj = -100;
            m_inj    = 0;
            m_drop   = 0;
            m_err    = 1'b0;
            ex       = '0;
            ey       = '0;
        end else begin
            cyc_n++;
            m_ready = (mq.size() < DEPTH);
            ex = '0;
            ey = '0;
            if (mq.size() > 0 && cyc_n - last_inj >= MINGAP) begin
                h = mq[0];
                if (h[74:72] != CUR_X) begin
                    if (!bus.xpos_stall) begin
                        ex = h; void'(mq.pop_front()); last_inj = cyc_n; m_inj = (m_inj + 1) % 65536;
                    end
                end else if (h[77:75] != CUR_Y) begin
                    if (!bus.ypos_stall) begin
                        ey = h; void'(mq.pop_front()); last_inj = cyc_n; m_inj = (m_inj + 1) % 65536;
                    end
                end else begin
                    void'(mq.pop_front());
                    if (m_drop < 255) m_drop++;
                    m_err = 1'b1;
                end
            end
            if (bus.in_valid && m_ready && bus.in_flit[81])
                mq.push_back({bus.in_children, bus.in_flit});
        end
    end

    bit chk_on = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_inject_xpos", bus.inject_xpos, ex);
            check("model_inject_ypos", bus.inject_ypos, ey);
            check("model_in_ready", bus.in_ready, (rst === 1'b1 && mq.size() < DEPTH));
            check("model_inj_count", inj_count, m_inj);
            check("model_drop_count", drop_count, m_drop);
            check("model_route_err", route_err, m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic present(input logic [FCW-1:0] e);
        bus.in_flit     = e[FW-1:0];
        bus.in_children = e[FCW-1:FW];
        bus.in_valid    = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [2:0]  dx, dy, dz, ch;
        logic        vb;
        logic [31:0] pl;
        int          port;   // 0 none, 1 xpos, 2 ypos
        int          dropped;
    } vec_t;

    vec_t           vt[6];
    logic [FCW-1:0] e, ye, xe;
    int             exp_inj, exp_drop, found, seen, acc;
    int             tcyc[4];

    initial begin
        vt[0] = '{3'd1, 3'd0, 3'd0, 3'b101, 1'b1, 32'hA5A5A5A5, 1, 0};
        vt[1] = '{3'd0, 3'd2, 3'd0, 3'd2,   1'b1, 32'h12345678, 2, 0};
        vt[2] = '{3'd7, 3'd3, 3'd1, 3'd7,   1'b1, 32'hFFFFFFFF, 1, 0};
        vt[3] = '{3'd0, 3'd0, 3'd3, 3'd1,   1'b1, 32'h0BADF00D, 0, 1};
        vt[4] = '{3'd1, 3'd0, 3'd0, 3'd4,   1'b0, 32'h55AA55AA, 0, 0};
        vt[5] = '{3'd0, 3'd5, 3'd7, 3'd0,   1'b1, 32'h00000001, 2, 0};

        bus.in_valid    = 1'b0;
        bus.in_flit     = '0;
        bus.in_children = '0;
        bus.xpos_stall  = 1'b0;
        bus.ypos_stall  = 1'b0;
        tick();
        tick();
        chk_on = 1'b1;
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_inj_count", inj_count, 0);
        rst = 1'b1;
        tick();

        // Reset discards queued flits
        bus.xpos_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(mk(3'(i), 3'd1, 3'd0, 3'd0, 1'b1, 32'h100 + i, 40'h0));
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("t1_ready_in_reset", bus.in_ready, 0);
        rst = 1'b1;
        bus.xpos_stall = 1'b0;
        tick();
        check("t1_ready_after", bus.in_ready, 1);
        check("t1_inject_x", bus.inject_xpos, 0);
        check("t1_inj_count", inj_count, 0);
        tick();
        tick();
        check("t1_no_stale_x", bus.inject_xpos, 0);

        // Vector table: one flit at a time from an empty queue
        do_reset();
        exp_inj  = 0;
        exp_drop = 0;
        for (int i = 0; i < 6; i++) begin
            e = mk(vt[i].ch, vt[i].dx, vt[i].dy, vt[i].dz, vt[i].vb, vt[i].pl, 40'h5A_0000_00A5);
            present(e);
            tick();
            bus.in_valid = 1'b0;
            tick();
            check($sformatf("vec%0d_xpos", i), bus.inject_xpos, (vt[i].port == 1) ? 128'(e) : 128'(0));
            check($sformatf("vec%0d_ypos", i), bus.inject_ypos, (vt[i].port == 2) ? 128'(e) : 128'(0));
            tick();
            check($sformatf("vec%0d_oneshot", i), bus.inject_xpos | bus.inject_ypos, 0);
            exp_inj  += (vt[i].port != 0) ? 1 : 0;
            exp_drop += vt[i].dropped;
            tick();
            tick();
            check($sformatf("vec%0d_inj_count", i), inj_count, exp_inj);
            check($sformatf("vec%0d_drop_count", i), drop_count, exp_drop);
        end
        check("vec_route_err", route_err, 1);

        // Stalled ypos head holds order
        bus.ypos_stall = 1'b1;
        ye = mk(3'd1, 3'd0, 3'd2, 3'd0, 1'b1, 32'hCAFE0003, 40'h0);
        xe = mk(3'd2, 3'd1, 3'd0, 3'd0, 1'b1, 32'hBEEF0003, 40'h0);
        present(ye);
        tick();
        present(xe);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_y_stalled", bus.inject_ypos, 0);
            check("t3_x_no_overtake", bus.inject_xpos, 0);
        end
        bus.ypos_stall = 1'b0;
        tick();
        check("t3_y_after_stall", bus.inject_ypos, ye);
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            tick();
            if (bus.inject_xpos == xe) found = 1;
        end
        check("t3_x_follows", found, 1);

        // Four back-to-back xpos flits: full queue, then paced injection
        bus.xpos_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            present(mk(3'(i), 3'd1, 3'd0, 3'd0, 1'b1, 32'h4000 + i, 40'h0));
            tick();
        end
        bus.in_valid = 1'b0;
        check("t4_full_ready", bus.in_ready, 0);
        bus.xpos_stall = 1'b0;
        seen = 0;
        for (int c = 0; c < 30 && seen < 4; c++) begin
            tick();
            if (bus.inject_xpos != '0) begin
                tcyc[seen] = c;
                seen++;
            end
        end
        check("t4_count", seen, 4);
        for (int j = 1; j < 4; j++)
            check($sformatf("t4_spacing%0d", j), tcyc[j] - tcyc[j-1], MINGAP);

        // Unroutable flits: drop, no injection, sticky error
        do_reset();
        present(mk(3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 32'hD0D0, 40'h0));
        tick();
        present(mk(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 32'hD1D1, 40'h0));
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_no_x", bus.inject_xpos, 0);
            check("t5_no_y", bus.inject_ypos, 0);
        end
        check("t5_drop_count", drop_count, 2);
        check("t5_route_err", route_err, 1);
        check("t5_inj_count", inj_count, 0);
        tick();
        tick();
        check("t5_err_sticky", route_err, 1);
        do_reset();
        check("t5_err_cleared", route_err, 0);

        // Drop counter saturation, then an invalid flit changes nothing
        acc = 0;
        for (int c = 0; c < 2000 && acc < 300; c++) begin
            present(mk(3'd0, 3'd0, 3'd0, 3'(c), 1'b1, 32'(c), 40'h0));
            if (bus.in_ready) acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        check("t6_accepted", acc, 300);
        for (int i = 0; i < 4; i++) tick();
        check("t6_drop_sat", drop_count, 255);
        present(mk(3'd3, 3'd1, 3'd0, 3'd0, 1'b0, 32'hDEAD, 40'h0));
        tick();
        present(mk(3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 32'hBEEF, 40'h0));
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t6_inv_drop", drop_count, 255);
        check("t6_inv_inj", inj_count, 0);

        // Randomized traffic with a mid-run reset
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            present(mk(3'($urandom_range(0, 7)),
                       ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                       ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                       3'($urandom_range(0, 7)),
                       ($urandom_range(0, 9) != 0),
                       $urandom(), 40'({$urandom(), $urandom()})));
            bus.in_valid   = ($urandom_range(0, 2) != 0);
            bus.xpos_stall = ($urandom_range(0, 3) == 0);
            bus.ypos_stall = ($urandom_range(0, 3) == 0);
            tick();
        end
        bus.in_valid   = 1'b0;
        bus.xpos_stall = 1'b0;
        bus.ypos_stall = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
